// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, requests words over req/ack,
// buffers {inst, pc+4} in a FIFO. Optional FETCH_STATS_EN adds drop/full counters.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        res,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
`ifdef FETCH_STATS_EN
    output logic [31:0] drop_cnt,
    output logic [31:0] full_cnt,
`endif
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc4
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_req;
    logic [31:0]        r_addr;
    logic [31:0]        w_addr_next;
    logic [31:0]        r_fetch_pc;
    logic [31:0]        w_fetch_pc_next;
    logic [31:0]        w_addr_plus4;
    logic [31:0]        r_inst [DEPTH];
    logic [31:0]        r_pc4  [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_next;
    logic               w_push;
    logic               w_pop;
    logic               w_room;

    assign inst_valid   = (r_count != '0);
    assign inst         = r_inst[r_rd_ptr];
    assign inst_pc4     = r_pc4[r_rd_ptr];
    assign imem_req     = r_req;
    assign imem_addr    = r_addr;
    assign w_addr_plus4 = r_addr + 32'd4;

    assign w_pop  = inst_valid & ~stall & ~redirect;
    assign w_push = imem_ack & (r_state == S_WAIT) & ~redirect;

    // Occupancy after this edge; redirect empties the queue.
    always_comb begin
        w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        if (redirect) begin
            w_count_next = '0;
        end
    end

    assign w_room = (w_count_next < CNT_W'(DEPTH));

    // Next-state, next fetch address and next fetch PC.
    always_comb begin
        w_state_next    = r_state;
        w_addr_next     = r_addr;
        w_fetch_pc_next = r_fetch_pc;
        case (r_state)
            S_IDLE: begin
                if (redirect) begin
                    w_state_next    = S_WAIT;
                    w_addr_next     = redirect_pc;
                    w_fetch_pc_next = redirect_pc;
                end else if (w_room) begin
                    w_state_next = S_WAIT;
                    w_addr_next  = r_fetch_pc;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    w_fetch_pc_next = redirect_pc;
                    if (imem_ack) begin
                        w_state_next = S_WAIT;
                        w_addr_next  = redirect_pc;
                    end else begin
                        w_state_next = S_DROP;
                    end
                end else if (imem_ack) begin
                    w_fetch_pc_next = w_addr_plus4;
                    w_addr_next     = w_addr_plus4;
                    w_state_next    = w_room ? S_WAIT : S_IDLE;
                end
            end
            S_DROP: begin
                // The outstanding request must complete before refetching.
                if (redirect) begin
                    w_fetch_pc_next = redirect_pc;
                end else if (imem_ack) begin
                    w_state_next = S_WAIT;
                    w_addr_next  = r_fetch_pc;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            r_state    <= S_IDLE;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_state    <= w_state_next;
            r_req      <= (w_state_next != S_IDLE);
            r_addr     <= w_addr_next;
            r_fetch_pc <= w_fetch_pc_next;
        end
    end

    // FIFO storage and pointers.
    always_ff @(posedge clk) begin
        if (!res) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_inst[i] <= 32'd0;
                r_pc4[i]  <= 32'd0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (redirect) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_inst[r_wr_ptr] <= imem_rdata;
                r_pc4[r_wr_ptr]  <= w_addr_plus4;
                r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_next;
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] r_drop_cnt;
    logic [31:0] r_full_cnt;
    logic        w_drop;

    assign w_drop = imem_ack & ((r_state == S_DROP) | ((r_state == S_WAIT) & redirect));

    always_ff @(posedge clk) begin
        if (!res) begin
            r_drop_cnt <= 32'd0;
            r_full_cnt <= 32'd0;
        end else begin
            r_drop_cnt <= r_drop_cnt + 32'(w_drop);
            r_full_cnt <= r_full_cnt + 32'(r_count == CNT_W'(DEPTH));
        end
    end

    assign drop_cnt = r_drop_cnt;
    assign full_cnt = r_full_cnt;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: scoreboard of expected PCs popped at the head.
`timescale 1ns/1ps
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        stall = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc4;

    logic        req_w;
    logic [31:0] addr_w;
    logic        ack_w;
    logic        stall_w = 1'b1;
    logic        valid_w;
    logic [31:0] inst_w;
    logic [31:0] pc4_w;
    logic        redirect_w = 1'b0;
    logic [31:0] redirect_pc_w = 32'd0;

`ifdef FETCH_STATS_EN
    logic [31:0] drop_cnt, full_cnt, drop_cnt_w, full_cnt_w;
`endif

    int          checks = 0;
    int          errors = 0;
    int          lat = 0;
    int          wcnt = 0;
    logic        late_ack = 1'b0;
    logic [31:0] data_xor = 32'd0;
    bit          mon_en = 1'b0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .res(res), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .stall(stall),
`ifdef FETCH_STATS_EN
        .drop_cnt(drop_cnt), .full_cnt(full_cnt),
`endif
        .inst_valid(inst_valid), .inst(inst), .inst_pc4(inst_pc4)
    );

    fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_dut_w (
        .clk(clk), .res(res), .imem_req(req_w), .imem_addr(addr_w),
        .imem_ack(ack_w), .imem_rdata(addr_w), .redirect(redirect_w),
        .redirect_pc(redirect_pc_w), .stall(stall_w),
`ifdef FETCH_STATS_EN
        .drop_cnt(drop_cnt_w), .full_cnt(full_cnt_w),
`endif
        .inst_valid(valid_w), .inst(inst_w), .inst_pc4(pc4_w)
    );

    // Memory: acks after lat extra request cycles, returns address (optionally scrambled).
    assign imem_ack   = (imem_req && (wcnt >= lat)) || late_ack;
    assign imem_rdata = imem_addr ^ data_xor;
    assign ack_w      = req_w;

    always @(posedge clk) begin
        if (!imem_req || imem_ack) wcnt <= 0;
        else                       wcnt <= wcnt + 1;
    end

    // Scoreboard: every head consumed must match the next expected PC.
    always @(negedge clk) begin
        if (mon_en && inst_valid && !stall && !redirect) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got inst=%h pc4=%h, required no pop", inst, inst_pc4);
            end else begin
                logic [31:0] exp_pc;
                exp_pc = sb.pop_front();
                if (inst !== (exp_pc ^ data_xor) || inst_pc4 !== exp_pc + 32'd4) begin
                    errors++;
                    $display("FAIL pop_data: got inst=%h pc4=%h, required inst=%h pc4=%h",
                             inst, inst_pc4, exp_pc ^ data_xor, exp_pc + 32'd4);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        res      = 1'b0;
        redirect = 1'b0;
        mon_en   = 1'b0;
        late_ack = 1'b0;
        sb.delete();
        tick;
        tick;
    endtask

    task automatic drain(input int maxc, output bit ok);
        int n = 0;
        while (sb.size() != 0 && n < maxc) begin
            tick;
            n++;
        end
        ok     = (sb.size() == 0);
        stall  = 1'b1;
        mon_en = 1'b0;
    endtask

    task automatic test_reset_stream;
        bit ok;
        lat = 0; data_xor = 32'd0; stall = 1'b0;
        do_reset;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b required 0", imem_req); end
        checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL rst_addr: got %h required 0", imem_addr); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", inst_valid); end
        checks++; if (inst !== 32'd0 || inst_pc4 !== 32'd0) begin errors++; $display("FAIL rst_head: got %h/%h required 0/0", inst, inst_pc4); end
`ifdef FETCH_STATS_EN
        checks++; if (drop_cnt !== 32'd0 || full_cnt !== 32'd0) begin errors++; $display("FAIL rst_stats: got %0d/%0d required 0/0", drop_cnt, full_cnt); end
`endif
        for (int i = 0; i < 8; i++) sb.push_back(32'(4 * i));
        mon_en = 1'b1;
        res = 1'b1;
        tick;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0 || inst_valid !== 1'b0) begin
            errors++; $display("FAIL first_req: got req=%b addr=%h valid=%b required 1/0/0", imem_req, imem_addr, inst_valid); end
        tick;
        checks++; if (inst_valid !== 1'b1 || inst !== 32'd0 || inst_pc4 !== 32'd4) begin
            errors++; $display("FAIL first_valid: got %b %h %h required 1 0 4", inst_valid, inst, inst_pc4); end
        for (int k = 1; k <= 5; k++) begin
            tick;
            checks++; if (inst_valid !== 1'b1 || inst !== 32'(4 * k)) begin
                errors++; $display("FAIL stream_%0d: got valid=%b inst=%h required 1 %h", k, inst_valid, inst, 32'(4 * k)); end
        end
        drain(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stream_drain: got %0d left required 0", sb.size()); end
    endtask

    task automatic test_full;
        bit ok;
        lat = 0; stall = 1'b1;
        do_reset;
        res = 1'b1;
        repeat (5) tick;
        checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b1 || inst !== 32'd0) begin
            errors++; $display("FAIL full_stop: got req=%b valid=%b inst=%h required 0 1 0", imem_req, inst_valid, inst); end
        repeat (3) tick;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL full_hold: got req=%b required 0", imem_req); end
        for (int i = 0; i < 6; i++) sb.push_back(32'(4 * i));
        mon_en = 1'b1;
        stall = 1'b0;
        tick;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd16 || inst !== 32'd4) begin
            errors++; $display("FAIL full_resume: got req=%b addr=%h inst=%h required 1 10 4", imem_req, imem_addr, inst); end
`ifdef FETCH_STATS_EN
        checks++; if (full_cnt !== 32'd4) begin errors++; $display("FAIL full_cnt: got %0d required 4", full_cnt); end
`endif
        drain(30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL full_drain: got %0d left required 0", sb.size()); end
    endtask

    task automatic test_redirect_drop;
        bit ok;
        lat = 2; stall = 1'b0;
        do_reset;
        res = 1'b1;
        tick;
        tick;
        redirect = 1'b1; redirect_pc = 32'h100;
        sb.push_back(32'h100); sb.push_back(32'h104);
        mon_en = 1'b1;
        tick;
        redirect = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0 || inst_valid !== 1'b0) begin
            errors++; $display("FAIL drop_hold: got req=%b addr=%h valid=%b required 1 0 0", imem_req, imem_addr, inst_valid); end
        tick;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || inst_valid !== 1'b0) begin
            errors++; $display("FAIL drop_refetch: got req=%b addr=%h valid=%b required 1 100 0", imem_req, imem_addr, inst_valid); end
`ifdef FETCH_STATS_EN
        checks++; if (drop_cnt !== 32'd1) begin errors++; $display("FAIL drop_cnt_a: got %0d required 1", drop_cnt); end
`endif
        tick;
        tick;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL drop_early: got valid=%b required 0", inst_valid); end
        tick;
        checks++; if (inst_valid !== 1'b1 || inst !== 32'h100 || inst_pc4 !== 32'h104) begin
            errors++; $display("FAIL drop_first: got %b %h %h required 1 100 104", inst_valid, inst, inst_pc4); end
        drain(30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL drop_drain: got %0d left required 0", sb.size()); end
    endtask

    task automatic test_redirect_ack;
        bit ok;
        lat = 0; stall = 1'b1;
        do_reset;
        res = 1'b1;
        tick;
        tick;
        redirect = 1'b1; redirect_pc = 32'h200;
        tick;
        redirect = 1'b0;
        checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            errors++; $display("FAIL rdack_flush: got valid=%b req=%b addr=%h required 0 1 200", inst_valid, imem_req, imem_addr); end
`ifdef FETCH_STATS_EN
        checks++; if (drop_cnt !== 32'd1) begin errors++; $display("FAIL drop_cnt_b: got %0d required 1", drop_cnt); end
`endif
        tick;
        checks++; if (inst_valid !== 1'b1 || inst !== 32'h200 || inst_pc4 !== 32'h204) begin
            errors++; $display("FAIL rdack_first: got %b %h %h required 1 200 204", inst_valid, inst, inst_pc4); end
        sb.push_back(32'h200); sb.push_back(32'h204); sb.push_back(32'h208);
        mon_en = 1'b1;
        stall = 1'b0;
        drain(30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rdack_drain: got %0d left required 0", sb.size()); end
    endtask

    task automatic test_wrap;
        logic [31:0] exp_pc4 [3];
        exp_pc4[0] = 32'hFFFF_FFFC; exp_pc4[1] = 32'h0000_0000; exp_pc4[2] = 32'h0000_0004;
        stall_w = 1'b1; stall = 1'b1;
        do_reset;
        res = 1'b1;
        tick;
        checks++; if (req_w !== 1'b1 || addr_w !== 32'hFFFF_FFF8) begin
            errors++; $display("FAIL wrap_a0: got req=%b addr=%h required 1 fffffff8", req_w, addr_w); end
        tick;
        checks++; if (addr_w !== 32'hFFFF_FFFC || pc4_w !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_a1: got addr=%h pc4=%h required fffffffc fffffffc", addr_w, pc4_w); end
        tick;
        checks++; if (addr_w !== 32'h0) begin errors++; $display("FAIL wrap_a2: got addr=%h required 0", addr_w); end
        repeat (3) tick;
        stall_w = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (valid_w !== 1'b1 || pc4_w !== exp_pc4[i] || inst_w !== exp_pc4[i] - 32'd4) begin
                errors++; $display("FAIL wrap_pc4_%0d: got valid=%b pc4=%h inst=%h required 1 %h %h",
                                   i, valid_w, pc4_w, inst_w, exp_pc4[i], exp_pc4[i] - 32'd4); end
            tick;
        end
        stall_w = 1'b1;
    endtask

    task automatic test_reset_mid;
        bit ok;
        lat = 2; stall = 1'b1; data_xor = 32'hA5A5_0000;
        do_reset;
        res = 1'b1;
        repeat (4) tick;
        checks++; if (inst_valid !== 1'b1 || inst !== 32'hA5A5_0000) begin
            errors++; $display("FAIL mid_pre: got valid=%b inst=%h required 1 a5a50000", inst_valid, inst); end
        tick;
        res = 1'b0;
        tick;
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'd0 || inst_valid !== 1'b0 || inst !== 32'd0 || inst_pc4 !== 32'd0) begin
            errors++; $display("FAIL mid_reset: got req=%b addr=%h valid=%b inst=%h pc4=%h required all 0",
                               imem_req, imem_addr, inst_valid, inst, inst_pc4); end
`ifdef FETCH_STATS_EN
        checks++; if (drop_cnt !== 32'd0 || full_cnt !== 32'd0) begin errors++; $display("FAIL mid_stats: got %0d/%0d required 0/0", drop_cnt, full_cnt); end
`endif
        late_ack = 1'b1;
        res = 1'b1;
        tick;
        late_ack = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0 || inst_valid !== 1'b0) begin
            errors++; $display("FAIL mid_late_ack: got req=%b addr=%h valid=%b required 1 0 0", imem_req, imem_addr, inst_valid); end
        sb.push_back(32'd0); sb.push_back(32'd4);
        mon_en = 1'b1;
        stall = 1'b0;
        drain(30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_drain: got %0d left required 0", sb.size()); end
        data_xor = 32'd0;
    endtask

    initial begin
        test_reset_stream;
        test_full;
        test_redirect_drop;
        test_redirect_ack;
        test_wrap;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front end of the 5-stage pipeline. It owns the fetch PC and issues word requests to instruction memory over a req/ack handshake. Returned instructions and their PC+4 are buffered in a small FIFO and presented to the IF/ID pipeline register. Branch and jump redirects flush the FIFO, and a hazard stall holds the FIFO head.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000: fetch PC after reset.

- clk  in  1  pipeline clock; all state updates on rising edge.
- res  in  1  reset; one clock, synchronous, active-low (res=0 resets on the edge).
- imem_req  out  1  fetch request, registered.
- imem_addr  out  32  word address of request, registered; stable while imem_req=1.
- imem_ack  in  1  memory accepted request and imem_rdata valid this cycle; meaningful only when imem_req=1.
- imem_rdata  in  32  instruction word.
- redirect  in  1  taken branch/jump; flush and refetch.
- redirect_pc  in  32  new fetch PC, sampled when redirect=1.
- stall  in  1  downstream cannot accept; hold head.
- inst_valid  out  1  FIFO head valid.
- inst  out  32  head instruction.
- inst_pc4  out  32  head PC+4 (feeds NextInst path).

## Operation
- State: fetch_pc, FIFO (DEPTH × {inst, pc4}), count (0..DEPTH), FSM {IDLE, WAIT, DROP}.
- pop = inst_valid & ~stall & ~redirect; push = imem_ack & (state==WAIT) & ~redirect.
- inst_valid = (count≠0); inst/inst_pc4 = head entry (combinational from registers).
- next_count = count + push − pop; push and pop in the same cycle allowed at any count including full.
- IDLE: imem_req=0. If count_next<DEPTH, go WAIT with imem_addr=fetch_pc.
- WAIT: imem_req=1. On ack: push {imem_rdata, imem_addr+4}; fetch_pc ← imem_addr+4; stay WAIT with imem_addr ← imem_addr+4 if next_count<DEPTH, else IDLE.
- DROP: imem_req=1, old address held. On ack: discard data, go WAIT with imem_addr=fetch_pc.
- redirect (priority over stall, push, pop): count ← 0, pointers ← 0, fetch_pc ← redirect_pc.
  - In IDLE, or in WAIT with ack the same cycle: go WAIT with imem_addr=redirect_pc; the ack'd data is discarded.
  - In WAIT without ack: go DROP.
  - In DROP: stay DROP; fetch_pc updated (last redirect wins).
- PC arithmetic is modulo 2^32; PC+4 wraps from 32'hFFFF_FFFC to 0.
- Pointers wrap modulo DEPTH.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc4=0; FSM=IDLE; count=0; fetch_pc=RESET_PC.
- First request: imem_req=1 in cycle 1 after res deasserts.
- Latency: ack at edge N, so inst_valid=1 and the new entry are visible after edge N.
- Zero-wait memory (ack tied to req) sustains 1 instruction/cycle.
- Full: no request is issued. Request restarts the cycle after a pop makes space, and IDLE→WAIT takes 1 cycle.
- Redirect at edge N: inst_valid=0 after N. The first redirected instruction is visible no earlier than edge N+1 (zero-wait memory). With a pending unacked request it arrives one ack after the dropped one.
- Reset mid-request: state cleared; any late ack while imem_req=0 is ignored.

## Configuration
- FETCH_STATS_EN defined: adds outputs drop_cnt (32, out) and full_cnt (32, out), both reset 0 and wrap at 2^32.
  - drop_cnt increments on each discarded ack (DROP ack, or ack with redirect).
  - full_cnt increments each cycle count==DEPTH.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset release, ack tied to req, memory returns addr as data: inst_valid rises in cycle 2 with inst=0, inst_pc4=4; then one word per cycle, 4, 8, 12…
- stall held high from the first valid, DEPTH=4: count reaches 4 and imem_req drops to 0. Release stall: entries 0,4,8,12 drain in order and fetch resumes at 16.
- 3-cycle memory latency, redirect to 0x100 in the 2nd wait cycle: FSM enters DROP and the old word is discarded. The next request address is 0x100 and the first valid is inst_pc4=0x104.
- Redirect in the same cycle as ack and stall=1: FIFO empty next cycle, acked word not pushed, request 0x200 issued; with FETCH_STATS_EN, drop_cnt=1.
- RESET_PC=32'hFFFF_FFF8: fetch addresses FFFF_FFF8, FFFF_FFFC, 0; inst_pc4 values FFFF_FFFC, 0, 4.
- res=0 asserted while waiting for an ack: next cycle all outputs are at reset values; the late ack is ignored; fetching restarts at RESET_PC.
